// File: rtl/stage_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// stage_sequencer_pkg
// Shared definitions for the multicycle stage sequencer:
//   - stage indices STG_IF..STG_WB and the default stage-vector width
//   - FSM state encodings (3-bit enum, SEQ_S_*)
//   - opcode/funct constants used to build the per-instruction stage mask
// ---------------------------------------------------------------------------
package stage_sequencer_pkg;

  localparam int OP_WIDTH       = 6;
  localparam int FUNCT_WIDTH    = 6;
  localparam int NUM_STAGES_DEF = 5;

  // Stage indices into stage_en and the stage mask
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef logic [NUM_STAGES_DEF-1:0] stage_mask_t;

  typedef enum logic [2:0] {
    SEQ_S_BOOT = 3'd0,
    SEQ_S_IF   = 3'd1,
    SEQ_S_ID   = 3'd2,
    SEQ_S_EX   = 3'd3,
    SEQ_S_MEM  = 3'd4,
    SEQ_S_WB   = 3'd5,
    SEQ_S_HALT = 3'd6
  } seq_state_t;

  // Opcodes
  localparam logic [OP_WIDTH-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_WIDTH-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_WIDTH-1:0] OP_LB    = 6'h20;
  localparam logic [OP_WIDTH-1:0] OP_LH    = 6'h21;
  localparam logic [OP_WIDTH-1:0] OP_LW    = 6'h23;
  localparam logic [OP_WIDTH-1:0] OP_LBU   = 6'h24;
  localparam logic [OP_WIDTH-1:0] OP_LHU   = 6'h25;
  localparam logic [OP_WIDTH-1:0] OP_SB    = 6'h28;
  localparam logic [OP_WIDTH-1:0] OP_SH    = 6'h29;
  localparam logic [OP_WIDTH-1:0] OP_SW    = 6'h2B;

  // I-type ALU ops occupy 0x08..0x0F, i.e. op_code[5:3] == 3'b001
  localparam logic [2:0] OP_IALU_HI3 = 3'b001;

  // R-type funct
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_JR = 6'h08;

  // Stage masks, bit order {WB, MEM, EX, ID, IF}
  localparam stage_mask_t MASK_BASE  = 5'b00111;
  localparam stage_mask_t MASK_WB    = 5'b10111;
  localparam stage_mask_t MASK_STORE = 5'b01111;
  localparam stage_mask_t MASK_LOAD  = 5'b11111;

endpackage

// File: rtl/stage_sequencer_mask_decode.sv
// ---------------------------------------------------------------------------
// stage_mask_decode
// Combinational decode of op_code/funct into the set of stages an
// instruction needs. IF, ID and EX are always present; MEM and WB are added
// only for instruction classes that use them. Unknown opcodes behave as NOPs.
// Ports:
//   op_code  in  decoded opcode
//   funct    in  decoded funct (only meaningful for R-type)
//   mask     out 5-bit stage mask {WB, MEM, EX, ID, IF}
// ---------------------------------------------------------------------------
module stage_mask_decode
  import stage_sequencer_pkg::*;
(
  input  logic [OP_WIDTH-1:0]    op_code,
  input  logic [FUNCT_WIDTH-1:0] funct,
  output stage_mask_t            mask
);

  always_comb begin
    mask = MASK_BASE;
    case (op_code)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: mask = MASK_LOAD;
      OP_SB, OP_SH, OP_SW:                 mask = MASK_STORE;
      OP_RTYPE: begin
        // JR only redirects the pc, so it has nothing to write back
        if (funct != FUNCT_JR) mask = MASK_WB;
      end
      OP_JAL:                              mask = MASK_WB;
      default: begin
        if (op_code[5:3] == OP_IALU_HI3) mask = MASK_WB;
      end
    endcase
  end

endmodule

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
// Multicycle stage sequencer. Walks each instruction through IF/ID/EX and,
// when needed, MEM/WB, emitting one-cycle clock-enable strobes for the stage
// registers instead of derived clocks. Waits on fetch/data-memory readies,
// honours an external stall and stops at instruction boundaries on halt_req.
//
// Optional feature: define SEQ_PERF_CNT_EN to build the cycle and retire
// performance counters; otherwise cycle_cnt/retire_cnt are constant 0.
//
// Ports:
//   clk           in  system clock, rising edge
//   rst           in  asynchronous, active-low reset
//   op_code/funct in  decoded instruction, sampled on the completing ID cycle
//   fetch_ready   in  instruction memory data valid this cycle
//   mem_ready     in  data memory access completes this cycle
//   stall         in  freeze FSM and mask all strobes
//   halt_req      in  stop at next instruction boundary, stay stopped while high
//   stage_en      out one-hot-or-zero stage strobe
//   inst_read_en  out fetch request, high throughout IF
//   mem_req       out data request, high throughout MEM
//   retire        out pulse on the completing cycle of the last stage
//   halted        out high while in HALT
//   cycle_cnt     out active-cycle counter
//   retire_cnt    out retired-instruction counter
// ---------------------------------------------------------------------------
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int W          = 32,
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_WIDTH-1:0]    op_code,
  input  logic [FUNCT_WIDTH-1:0] funct,
  input  logic                   fetch_ready,
  input  logic                   mem_ready,
  input  logic                   stall,
  input  logic                   halt_req,
  output logic [NUM_STAGES-1:0]  stage_en,
  output logic                   inst_read_en,
  output logic                   mem_req,
  output logic                   retire,
  output logic                   halted,
  output logic [W-1:0]           cycle_cnt,
  output logic [W-1:0]           retire_cnt
);

  seq_state_t  state_q, state_d;
  stage_mask_t mask_q, mask_dec;
  stage_mask_t strobe;
  seq_state_t  after_retire;

  stage_mask_decode u_mask_decode (
    .op_code (op_code),
    .funct   (funct),
    .mask    (mask_dec)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SEQ_S_BOOT;
    else      state_q <= state_d;
  end

  // The stage mask is captured when ID completes so that later stages are
  // independent of whatever the decoder shows after that point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  mask_q <= '0;
    else if (state_q == SEQ_S_ID && !stall)    mask_q <= mask_dec;
  end

  // Next-state logic; stall freezes every state except BOOT and HALT
  always_comb begin
    state_d      = state_q;
    after_retire = halt_req ? SEQ_S_HALT : SEQ_S_IF;
    case (state_q)
      SEQ_S_BOOT: state_d = SEQ_S_IF;
      SEQ_S_IF:   if (fetch_ready && !stall) state_d = SEQ_S_ID;
      SEQ_S_ID:   if (!stall) state_d = SEQ_S_EX;
      SEQ_S_EX: begin
        if (!stall) begin
          if (mask_q[STG_MEM])     state_d = SEQ_S_MEM;
          else if (mask_q[STG_WB]) state_d = SEQ_S_WB;
          else                     state_d = after_retire;
        end
      end
      SEQ_S_MEM: begin
        if (mem_ready && !stall) begin
          if (mask_q[STG_WB]) state_d = SEQ_S_WB;
          else                state_d = after_retire;
        end
      end
      SEQ_S_WB:   if (!stall) state_d = after_retire;
      SEQ_S_HALT: if (!halt_req) state_d = SEQ_S_IF;
      default:    state_d = SEQ_S_BOOT;
    endcase
  end

  // Outputs: level requests are pure Moore; strobes and retire also need the
  // stage's completion condition, which stall always overrides.
  always_comb begin
    strobe       = '0;
    inst_read_en = 1'b0;
    mem_req      = 1'b0;
    retire       = 1'b0;
    halted       = 1'b0;
    case (state_q)
      SEQ_S_IF: begin
        inst_read_en = 1'b1;
        if (fetch_ready && !stall) strobe[STG_IF] = 1'b1;
      end
      SEQ_S_ID: begin
        if (!stall) strobe[STG_ID] = 1'b1;
      end
      SEQ_S_EX: begin
        if (!stall) begin
          strobe[STG_EX] = 1'b1;
          retire         = !mask_q[STG_MEM] && !mask_q[STG_WB];
        end
      end
      SEQ_S_MEM: begin
        mem_req = 1'b1;
        if (mem_ready && !stall) begin
          strobe[STG_MEM] = 1'b1;
          retire          = !mask_q[STG_WB];
        end
      end
      SEQ_S_WB: begin
        if (!stall) begin
          strobe[STG_WB] = 1'b1;
          retire         = 1'b1;
        end
      end
      SEQ_S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // Stage vector may be wider than the five defined stages; extra bits stay 0
  always_comb begin
    stage_en                     = '0;
    stage_en[NUM_STAGES_DEF-1:0] = strobe;
  end

`ifdef SEQ_PERF_CNT_EN
  logic [W-1:0] cycle_cnt_q, retire_cnt_q;

  // Active cycles include stalled and wait cycles, but not BOOT or HALT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (state_q != SEQ_S_BOOT && state_q != SEQ_S_HALT)
        cycle_cnt_q <= cycle_cnt_q + W'(1);
      if (retire)
        retire_cnt_q <= retire_cnt_q + W'(1);
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stage_sequencer
// Directed instruction sequences for stage_sequencer. Each issued
// instruction pushes its expected strobe/retire sequence into a queue; a
// monitor pops one entry every cycle the DUT strobes or retires.
// ---------------------------------------------------------------------------
module tb_stage_sequencer;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic [5:0]    op_code;
  logic [5:0]    funct;
  logic          fetch_ready;
  logic          mem_ready;
  logic          stall;
  logic          halt_req;
  logic [4:0]    stage_en;
  logic          inst_read_en;
  logic          mem_req;
  logic          retire;
  logic          halted;
  logic [W-1:0]  cycle_cnt;
  logic [W-1:0]  retire_cnt;

  typedef struct packed {
    logic [4:0] en;
    logic       ret;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cpi;
  int   memc;

  stage_sequencer #(.W(W), .NUM_STAGES(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_code      (op_code),
    .funct        (funct),
    .fetch_ready  (fetch_ready),
    .mem_ready    (mem_ready),
    .stall        (stall),
    .halt_req     (halt_req),
    .stage_en     (stage_en),
    .inst_read_en (inst_read_en),
    .mem_req      (mem_req),
    .retire       (retire),
    .halted       (halted),
    .cycle_cnt    (cycle_cnt),
    .retire_cnt   (retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe/retire cycle must match the next queued expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (stage_en !== 5'b0 || retire !== 1'b0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected actual=%b/%b expected=none", stage_en, retire);
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_strobe", {58'b0, stage_en, retire}, {58'b0, e.en, e.ret});
        end
      end
    end
  end

  // Runs one instruction, entered on the falling edge of its first IF cycle.
  // Returns on the falling edge after retire, with cpi and MEM request cycles.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] mask, input int fetch_wait,
                               input int mem_wait, input int stall_cyc,
                               input int halt_at, output int cpi_o,
                               output int mem_o);
    int   last;
    exp_t e;
    bit   done;
    bit   stalled;
    last = 0;
    for (int s = 0; s < 5; s++) if (mask[s]) last = s;
    for (int s = 0; s < 5; s++) begin
      if (mask[s]) begin
        e.en  = 5'b00001 << s;
        e.ret = (s == last);
        sb_q.push_back(e);
      end
    end
    op_code = op;
    funct   = fn;
    cpi_o   = 0;
    mem_o   = 0;
    done    = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      stall       = 1'b0;
      fetch_ready = 1'b1;
      mem_ready   = 1'b1;
      stalled     = 1'b0;
      if (inst_read_en) begin
        if (stall_cyc > 0) begin
          stall     = 1'b1;
          stall_cyc--;
          stalled   = 1'b1;
        end else if (fetch_wait > 0) begin
          fetch_ready = 1'b0;
          fetch_wait--;
        end
      end
      if (mem_req) begin
        mem_o++;
        if (mem_wait > 0) begin
          mem_ready = 1'b0;
          mem_wait--;
        end
      end
      if (k == halt_at) halt_req = 1'b1;
      #2;
      cpi_o = k;
      if (stalled) checkOutput("stall_mask", {58'b0, stage_en, inst_read_en}, {58'b0, 5'b0, 1'b1});
      if (retire) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL retire_timeout actual=no_retire expected=retire op=%0h", op);
    end
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b0;
    op_code     = 6'h00;
    funct       = 6'h00;
    fetch_ready = 1'b1;
    mem_ready   = 1'b1;
    stall       = 1'b0;
    halt_req    = 1'b0;

    #3;
    checkOutput("reset_outputs", {55'b0, stage_en, inst_read_en, mem_req, retire, halted}, 64'd0);
    checkOutput("reset_counters", {cycle_cnt, retire_cnt}, 64'd0);

    @(negedge clk);
    rst = 1'b1;
    #2;
    checkOutput("boot_outputs", {55'b0, stage_en, inst_read_en, mem_req, retire, halted}, 64'd0);
    @(negedge clk);

    applyStimulus(6'h23, 6'h00, 5'b11111, 0, 0, 0, 0, cpi, memc);
    checkOutput("cpi_lw", cpi, 5);
    checkOutput("memreq_lw", memc, 1);

    applyStimulus(6'h04, 6'h00, 5'b00111, 0, 0, 0, 0, cpi, memc);
    checkOutput("cpi_beq", cpi, 3);
    applyStimulus(6'h00, 6'h20, 5'b10111, 0, 0, 0, 0, cpi, memc);
    checkOutput("cpi_add", cpi, 4);

    applyStimulus(6'h2B, 6'h00, 5'b01111, 0, 3, 0, 0, cpi, memc);
    checkOutput("cpi_sw_wait", cpi, 7);
    checkOutput("memreq_sw_wait", memc, 4);

    applyStimulus(6'h00, 6'h20, 5'b10111, 0, 0, 2, 0, cpi, memc);
    checkOutput("cpi_add_stall", cpi, 6);

    applyStimulus(6'h00, 6'h20, 5'b10111, 0, 0, 0, 3, cpi, memc);
    checkOutput("cpi_add_halt", cpi, 4);
    checkOutput("halt_enter", {58'b0, halted, inst_read_en, stage_en}, {58'b0, 1'b1, 1'b0, 5'b0});
    @(negedge clk);
    checkOutput("halt_hold", {61'b0, halted, inst_read_en, retire}, {61'b0, 1'b1, 1'b0, 1'b0});
    halt_req = 1'b0;
    @(negedge clk);
    checkOutput("halt_resume", {62'b0, halted, inst_read_en}, {62'b0, 1'b0, 1'b1});

    applyStimulus(6'h00, 6'h08, 5'b00111, 0, 0, 0, 0, cpi, memc);
    checkOutput("cpi_jr", cpi, 3);
    applyStimulus(6'h08, 6'h00, 5'b10111, 0, 0, 0, 0, cpi, memc);
    checkOutput("cpi_addi", cpi, 4);
    applyStimulus(6'h03, 6'h00, 5'b10111, 0, 0, 0, 0, cpi, memc);
    checkOutput("cpi_jal", cpi, 4);
    applyStimulus(6'h3F, 6'h00, 5'b00111, 0, 0, 0, 0, cpi, memc);
    checkOutput("cpi_unknown", cpi, 3);
    applyStimulus(6'h20, 6'h00, 5'b11111, 2, 0, 0, 0, cpi, memc);
    checkOutput("cpi_lb_fetch_wait", cpi, 7);

    // Fresh counters, then ten back-to-back branches
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(6'h04, 6'h00, 5'b00111, 0, 0, 0, 0, cpi, memc);
    end
`ifdef SEQ_PERF_CNT_EN
    checkOutput("perf_cycle_cnt", {32'b0, cycle_cnt}, 64'd30);
    checkOutput("perf_retire_cnt", {32'b0, retire_cnt}, 64'd10);
`else
    checkOutput("perf_cycle_cnt", {32'b0, cycle_cnt}, 64'd0);
    checkOutput("perf_retire_cnt", {32'b0, retire_cnt}, 64'd0);
`endif

    // Reset while a load is waiting in MEM
    begin
      exp_t e;
      e.ret = 1'b0;
      e.en = 5'b00001; sb_q.push_back(e);
      e.en = 5'b00010; sb_q.push_back(e);
      e.en = 5'b00100; sb_q.push_back(e);
    end
    op_code     = 6'h23;
    funct       = 6'h00;
    mem_ready   = 1'b0;
    fetch_ready = 1'b1;
    stall       = 1'b0;
    for (int k = 0; k < 20 && !mem_req; k++) @(negedge clk);
    checkOutput("reach_mem", {63'b0, mem_req}, 64'd1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("mid_mem_reset_outputs", {55'b0, stage_en, inst_read_en, mem_req, retire, halted}, 64'd0);
    checkOutput("mid_mem_reset_counters", {cycle_cnt, retire_cnt}, 64'd0);
    @(negedge clk);
    checkOutput("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised multicycle stage sequencer: the successor to the fixed five-stage counter in the multicycle CPU top. It emits per-stage clock-enable strobes rather than derived clocks, and skips stages an instruction does not need (no MEM for ALU ops, no WB for stores and branches). It inserts wait states on instruction-fetch and data-memory handshakes, and supports external stall and halt. It sits between the instruction/data memory controllers and the pc, decoder, ALU, mem and writeback units, all of which run on `clk`.

## Interface
- `W`, 32: width of performance counters.
- `NUM_STAGES`, 5: stage-enable vector width; stage indices IF=0, ID=1, EX=2, MEM=3, WB=4.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `op_code`  in  `OP_WIDTH`  decoded opcode; sampled on the completing cycle of ID.
- `funct`  in  `FUNCT_WIDTH`  decoded funct; sampled with `op_code`.
- `fetch_ready`  in  1  instruction memory returns valid data this cycle.
- `mem_ready`  in  1  data memory access completes this cycle.
- `stall`  in  1  external hold; freezes the FSM and masks all strobes.
- `halt_req`  in  1  stop at the next instruction boundary and remain stopped while high.
- `stage_en`  out  `NUM_STAGES`  one-hot-or-zero strobe; stage registers capture when their bit is high.
- `inst_read_en`  out  1  fetch request; level signal, high throughout IF.
- `mem_req`  out  1  data request; level signal, high throughout MEM.
- `retire`  out  1  one-cycle pulse on the completing cycle of an instruction's last stage.
- `halted`  out  1  high while in HALT.
- `cycle_cnt`  out  W  active-cycle counter.
- `retire_cnt`  out  W  retired-instruction counter.

## Operation
- States: BOOT, IF, ID, EX, MEM, WB, HALT. Moore outputs plus ready/stall gating.
- BOOT: entered on reset. All outputs are 0. Moves to IF on the first clock after `rst` rises.
- IF: `inst_read_en`=1. Completes when `fetch_ready` & !`stall`. On completion, `stage_en[IF]`=1 and the FSM goes to ID.
- ID: completes when !`stall`. On completion, `stage_en[ID]`=1, the stage mask is latched from `op_code`/`funct`, and the FSM goes to EX.
- EX: completes when !`stall`. Next state is MEM if mask.MEM, else WB if mask.WB, else retire.
- MEM: `mem_req`=1. Completes when `mem_ready` & !`stall`. Next state is WB if mask.WB, else retire.
- WB: completes when !`stall`, then retire.
- Retire: `retire`=1 on the completing cycle. Next state is HALT if `halt_req`, else IF.
- HALT: `halted`=1, all strobes are 0. Returns to IF on the first cycle `halt_req` is sampled low.
- Stage mask (IF, ID, EX are always set):
  - Loads 0x20/0x21/0x23/0x24/0x25: +MEM +WB.
  - Stores 0x28/0x29/0x2B: +MEM.
  - R-type (op 0) except JR (funct 0x08): +WB.
  - JR: none added.
  - I-ALU 0x08–0x0F: +WB.
  - JAL 0x03: +WB.
  - Branches 0x01, 0x04–0x07 and J 0x02: none added.
  - Unknown opcodes: none added (treated as NOP).
- `stall` dominates: when `stall` and a ready arrive in the same cycle, there is no strobe and no advance, and the level requests stay asserted.
- `halt_req` is sampled only at retire and in HALT. Asserting it mid-instruction never truncates that instruction.
- Reset mid-operation: asynchronously returns to BOOT, all outputs 0, mask cleared, counters cleared.

## Timing
- CPI with zero wait states: branch/J/JR 3; ALU/JAL 4; store 4; load 5.
- Each IF or MEM wait cycle adds 1 cycle; each stall cycle adds 1 cycle.
- `stage_en`, `retire` and `halted` are combinational from the state register and inputs; there is no added latency.
- `stage_en` is never multi-hot. Each stage strobes exactly once per instruction, or zero times if skipped.

## Configuration
- `SEQ_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every clock whose state is neither BOOT nor HALT.
  - `retire_cnt` increments on `retire`.
  - Both wrap modulo 2^W and reset to 0.
- `SEQ_PERF_CNT_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Added to `defines.v`: stage indices `STG_IF..STG_WB`, `NUM_STAGES_DEF`, state encodings `SEQ_S_*` (3-bit), and opcode/funct constants used by the mask.
- One sub-module, `stage_mask_decode`: combinational `op_code`/`funct` → 5-bit mask.

## Test plan
- Release reset, `fetch_ready`=1, `mem_ready`=1, LW (op 0x23) → `stage_en` 00001, 00010, 00100, 01000, 10000 on cycles 2–6; `retire` on cycle 6.
- BEQ (0x04), then ADD (op 0, funct 0x20) → strobes IF, ID, EX with retire at EX; then IF, ID, EX, WB with retire at WB.
- SW (0x2B) with `mem_ready` low for 3 cycles → `mem_req` high for 4 cycles, `stage_en[MEM]` exactly once, no WB strobe, CPI 7.
- `stall` high together with `fetch_ready` for 2 cycles → no strobe and `inst_read_en` held; IF strobe on the first unstalled ready cycle.
- `halt_req` raised during EX of an ALU op → WB completes, `retire`, then `halted`=1. Drop `halt_req` → IF on the next cycle.
- With `SEQ_PERF_CNT_EN`, 10 BEQs → `retire_cnt`=10, `cycle_cnt`=30. Without the macro → both 0. Reset asserted mid-MEM → all outputs 0 immediately.
